// File: rtl/prio_enc_deb.sv
// Priority encoder for a bank of board switches.
// The switch vector is synchronised, then debounced, then encoded to the index of the winning
// set bit. The index, valid and change pulse are registered. Two hex 7-segment digits are
// decoded from the registered index.
module prio_enc_deb #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEB_CYCLES = 16,
   localparam int unsigned IDXW      = $clog2(WIDTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [WIDTH-1:0] sw,
   input  logic            msb_first,
   input  logic            hold,
   output logic [IDXW-1:0] idx,
   output logic            valid,
   output logic            chg,
   output logic [7:0]      seg_lo,
   output logic [7:0]      seg_hi
);

   localparam int unsigned CNTW     = $clog2(DEB_CYCLES + 1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEB_CYCLES - 1);
   localparam int          W        = int'(WIDTH);

   logic [WIDTH-1:0] s1, s2;
   logic [WIDTH-1:0] cand;
   logic [WIDTH-1:0] stable;
   logic [CNTW-1:0]  cnt;
   logic [IDXW-1:0]  next_idx;
   logic             next_valid;
   logic [7:0]       idx_ext;

   // Active-low hex digit patterns, {dp,g,f,e,d,c,b,a}, decimal point off.
   function automatic logic [7:0] hex7(input logic [3:0] d);
      logic [7:0] s;
      unique case (d)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   // Two-flop synchroniser for the asynchronous switch pins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= sw;
         s2 <= s1;
      end
   end

   // Debounce: a candidate must stay unchanged for DEB_CYCLES edges before it becomes stable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cand   <= '0;
         cnt    <= '0;
         stable <= '0;
      end else if (s2 != cand) begin
         cand <= s2;
         cnt  <= '0;
      end else if (cnt == CNT_LAST) begin
         stable <= cand;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Encode: the last match in scan order wins, so scan upwards for MSB-first and
   // downwards for LSB-first.
   always_comb begin
      next_idx   = '0;
      next_valid = |stable;
      for (int i = 0; i < W; i++) begin
         if (msb_first) begin
            if (stable[i]) next_idx = IDXW'(i);
         end else begin
            if (stable[W-1-i]) next_idx = IDXW'(W - 1 - i);
         end
      end
   end

   // Output register; hold freezes idx/valid and suppresses the change pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx   <= '0;
         valid <= 1'b0;
         chg   <= 1'b0;
      end else if (hold) begin
         chg <= 1'b0;
      end else begin
         idx   <= next_idx;
         valid <= next_valid;
         chg   <= ({next_valid, next_idx} != {valid, idx});
      end
   end

   // Segment decode from the registered index; both digits blank while not valid.
   always_comb begin
      idx_ext            = '0;
      idx_ext[IDXW-1:0]  = idx;
      seg_lo             = 8'hFF;
      seg_hi             = 8'hFF;
      if (valid) begin
         seg_lo = hex7(idx_ext[3:0]);
         seg_hi = hex7(idx_ext[7:4]);
      end
   end

endmodule

// File: tb/tb_prio_enc_deb.sv
// Scoreboard bench for prio_enc_deb: an 8-bit and a 256-bit instance, DEB_CYCLES=4.
// Stimulus pushes expected updates (with the cycle they must appear on); monitors pop them on
// every chg pulse.
module tb_prio_enc_deb;

   localparam int unsigned DEB = 4;

   typedef struct {
      int unsigned cyc;
      logic [7:0]  idx;
      logic        valid;
      logic [7:0]  lo;
      logic [7:0]  hi;
   } exp_t;

   logic         clk    = 1'b0;
   logic         rst    = 1'b0;
   logic         rst256 = 1'b0;
   logic [7:0]   sw8    = '0;
   logic         msb8   = 1'b1;
   logic         hold8  = 1'b0;
   logic [2:0]   idx8;
   logic         valid8, chg8;
   logic [7:0]   lo8, hi8;
   logic [255:0] sw256  = '0;
   logic         msb256 = 1'b1;
   logic         hold256 = 1'b0;
   logic [7:0]   idx256;
   logic         valid256, chg256;
   logic [7:0]   lo256, hi256;

   int unsigned cyc      = 0;
   int          checks   = 0;
   int          failures = 0;
   exp_t        q8[$];
   exp_t        q256[$];

   prio_enc_deb #(.WIDTH(8), .DEB_CYCLES(DEB)) dut8 (
      .clk(clk), .rst(rst), .sw(sw8), .msb_first(msb8), .hold(hold8),
      .idx(idx8), .valid(valid8), .chg(chg8), .seg_lo(lo8), .seg_hi(hi8)
   );

   prio_enc_deb #(.WIDTH(256), .DEB_CYCLES(DEB)) dut256 (
      .clk(clk), .rst(rst256), .sw(sw256), .msb_first(msb256), .hold(hold256),
      .idx(idx256), .valid(valid256), .chg(chg256), .seg_lo(lo256), .seg_hi(hi256)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push8(input logic [7:0] i, input logic v, input logic [7:0] lo,
                        input logic [7:0] hi, input int unsigned dly);
      exp_t e;
      e.cyc = cyc + dly; e.idx = i; e.valid = v; e.lo = lo; e.hi = hi;
      q8.push_back(e);
   endtask

   task automatic push256(input logic [7:0] i, input logic v, input logic [7:0] lo,
                          input logic [7:0] hi, input int unsigned dly);
      exp_t e;
      e.cyc = cyc + dly; e.idx = i; e.valid = v; e.lo = lo; e.hi = hi;
      q256.push_back(e);
   endtask

   // Monitor for the 8-bit instance.
   always @(negedge clk) begin
      if (chg8 === 1'b1) begin
         if (q8.size() == 0) begin
            chk("chg8_unexpected", 32'(cyc), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = q8.pop_front();
            chk("chg8_cycle", 32'(cyc), 32'(e.cyc));
            chk("idx8", 32'(idx8), 32'(e.idx));
            chk("valid8", 32'(valid8), 32'(e.valid));
            chk("seg_lo8", 32'(lo8), 32'(e.lo));
            chk("seg_hi8", 32'(hi8), 32'(e.hi));
         end
      end
   end

   // Monitor for the 256-bit instance.
   always @(negedge clk) begin
      if (chg256 === 1'b1) begin
         if (q256.size() == 0) begin
            chk("chg256_unexpected", 32'(cyc), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = q256.pop_front();
            chk("chg256_cycle", 32'(cyc), 32'(e.cyc));
            chk("idx256", 32'(idx256), 32'(e.idx));
            chk("valid256", 32'(valid256), 32'(e.valid));
            chk("seg_lo256", 32'(lo256), 32'(e.lo));
            chk("seg_hi256", 32'(hi256), 32'(e.hi));
         end
      end
   end

   initial begin
      @(negedge clk);
      chk("rst_idx8", 32'(idx8), 32'h0);
      chk("rst_valid8", 32'(valid8), 32'h0);
      chk("rst_chg8", 32'(chg8), 32'h0);
      chk("rst_lo8", 32'(lo8), 32'hFF);
      chk("rst_hi8", 32'(hi8), 32'hFF);
      chk("rst_idx256", 32'(idx256), 32'h0);
      chk("rst_lo256", 32'(lo256), 32'hFF);
      chk("rst_hi256", 32'(hi256), 32'hFF);
      rst    = 1'b1;
      rst256 = 1'b1;
      repeat (3) @(negedge clk);

      // Wide instance: bits 200 and 3 set.
      sw256[200] = 1'b1;
      sw256[3]   = 1'b1;
      push256(8'hC8, 1'b1, 8'h80, 8'hC6, DEB + 4);
      repeat (10) @(negedge clk);
      msb256 = 1'b0;
      push256(8'h03, 1'b1, 8'hB0, 8'hC0, 1);
      repeat (3) @(negedge clk);

      // Basic encode, MSB-first.
      sw8 = 8'h24;
      push8(8'd5, 1'b1, 8'h92, 8'hC0, DEB + 4);
      repeat (10) @(negedge clk);

      // Mode switch to LSB-first.
      msb8 = 1'b0;
      push8(8'd2, 1'b1, 8'hA4, 8'hC0, 1);
      repeat (3) @(negedge clk);

      // Same encoding after a data change: no pulse expected.
      sw8 = 8'h2C;
      repeat (10) @(negedge clk);
      msb8 = 1'b1;
      push8(8'd5, 1'b1, 8'h92, 8'hC0, 1);
      repeat (3) @(negedge clk);

      // Bounce every 2 cycles, ending on 0x80 which is then held.
      for (int i = 0; i < 10; i++) begin
         sw8 = ((i % 2) == 1) ? 8'h80 : 8'h00;
         if (i == 9) push8(8'd7, 1'b1, 8'hF8, 8'hC0, DEB + 4);
         repeat (2) @(negedge clk);
      end
      repeat (10) @(negedge clk);

      // Hold freezes outputs while the pipeline keeps running.
      hold8 = 1'b1;
      sw8   = 8'h01;
      repeat (20) @(negedge clk);
      chk("hold_idx8", 32'(idx8), 32'd7);
      chk("hold_valid8", 32'(valid8), 32'd1);
      chk("hold_lo8", 32'(lo8), 32'hF8);
      chk("hold_hi8", 32'(hi8), 32'hC0);
      hold8 = 1'b0;
      push8(8'd0, 1'b1, 8'hC0, 8'hC0, 1);
      repeat (3) @(negedge clk);

      // Reset two cycles into a debounce count.
      sw8 = 8'h10;
      repeat (4) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst_idx8", 32'(idx8), 32'h0);
      chk("midrst_valid8", 32'(valid8), 32'h0);
      chk("midrst_chg8", 32'(chg8), 32'h0);
      chk("midrst_lo8", 32'(lo8), 32'hFF);
      chk("midrst_hi8", 32'(hi8), 32'hFF);
      @(negedge clk);
      rst = 1'b1;
      push8(8'd4, 1'b1, 8'h99, 8'hC0, DEB + 4);
      repeat (10) @(negedge clk);

      // Zero input from a valid state.
      sw8 = 8'h00;
      push8(8'd0, 1'b0, 8'hFF, 8'hFF, DEB + 4);
      repeat (10) @(negedge clk);

      chk("q8_drained", 32'(q8.size()), 32'd0);
      chk("q256_drained", 32'(q256.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
